// File: rtl/decode_execute_core.sv
// ID/EX slice of a five-stage MIPS pipeline: register file, field extraction,
// ALU with MEM->EX forwarding, branch-target adder and the EX/MEM register.
module decode_execute_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr_id,
    input  logic        wb_reg_write,
    input  logic [4:0]  wb_dst,
    input  logic [31:0] wb_data,
    output logic [31:0] id_rs_data,
    output logic [31:0] id_rt_data,
    output logic [31:0] id_imm,
    output logic [4:0]  id_rs,
    output logic [4:0]  id_rt,
    output logic [4:0]  id_rd,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic [31:0] ex_imm,
    input  logic        ex_alu_src,
    input  logic [1:0]  ex_alu_op,
    input  logic [4:0]  ex_dst,
    input  logic        ex_branch,
    input  logic        ex_wb,
    input  logic        fwd_a,
    input  logic        fwd_b,
    output logic [31:0] mem_branch_target,
    output logic [31:0] mem_alu_result,
    output logic        mem_zero,
    output logic [4:0]  mem_dst,
    output logic        mem_branch,
    output logic        mem_wb
);

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_OR    = 2'b11;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    logic [31:0] regs_r [32];

    logic        wb_active_s;
    logic [31:0] op_a_s;
    logic [31:0] op_bf_s;
    logic [31:0] op_b_s;
    logic [31:0] alu_result_s;
    logic [31:0] branch_target_s;
    logic        zero_s;

    // Register file may be read for the register being written this cycle.
    function automatic logic [31:0] read_port(
        input logic [4:0]  addr,
        input logic        wr_en,
        input logic [4:0]  wr_addr,
        input logic [31:0] wr_data,
        input logic [31:0] stored
    );
        logic [31:0] val;
        if (addr == 5'd0) begin
            val = 32'd0;
        end else if (wr_en && (wr_addr == addr)) begin
            val = wr_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Signed set-less-than, result 1 or 0.
    function automatic logic [31:0] slt32(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        if ($signed(a) < $signed(b)) begin
            r = 32'd1;
        end else begin
            r = 32'd0;
        end
        return r;
    endfunction

    assign wb_active_s = wb_reg_write && (wb_dst != 5'd0);

    // Register file storage: reset preloads register i with i; reset beats writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'(i);
            end
        end else if (wb_active_s) begin
            regs_r[wb_dst] <= wb_data;
        end
    end

    // ID-stage field extraction and register reads.
    always_comb begin
        id_rs      = instr_id[25:21];
        id_rt      = instr_id[20:16];
        id_rd      = instr_id[15:11];
        id_imm     = {{16{instr_id[15]}}, instr_id[15:0]};
        id_rs_data = read_port(instr_id[25:21], wb_active_s, wb_dst, wb_data,
                               regs_r[instr_id[25:21]]);
        id_rt_data = read_port(instr_id[20:16], wb_active_s, wb_dst, wb_data,
                               regs_r[instr_id[20:16]]);
    end

    // Operand selection with forwarding from the EX/MEM register.
    always_comb begin
        if (fwd_a) begin
            op_a_s = mem_alu_result;
        end else begin
            op_a_s = ex_rs_data;
        end
        if (fwd_b) begin
            op_bf_s = mem_alu_result;
        end else begin
            op_bf_s = ex_rt_data;
        end
        if (ex_alu_src) begin
            op_b_s = ex_imm;
        end else begin
            op_b_s = op_bf_s;
        end
    end

    // ALU; for R-type the funct field lives in the low bits of the immediate.
    always_comb begin
        alu_result_s = 32'd0;
        case (ex_alu_op)
            ALU_ADD: alu_result_s = op_a_s + op_b_s;
            ALU_SUB: alu_result_s = op_a_s - op_b_s;
            ALU_OR:  alu_result_s = op_a_s | op_b_s;
            ALU_FUNCT: begin
                case (ex_imm[5:0])
                    FN_ADD:  alu_result_s = op_a_s + op_b_s;
                    FN_SUB:  alu_result_s = op_a_s - op_b_s;
                    FN_AND:  alu_result_s = op_a_s & op_b_s;
                    FN_OR:   alu_result_s = op_a_s | op_b_s;
                    FN_SLT:  alu_result_s = slt32(op_a_s, op_b_s);
                    default: alu_result_s = 32'd0;
                endcase
            end
            default: alu_result_s = 32'd0;
        endcase
    end

    assign zero_s          = (alu_result_s == 32'd0);
    assign branch_target_s = ex_pc + {ex_imm[29:0], 2'b00};

    // EX/MEM pipeline register, captured every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_branch_target <= 32'd0;
            mem_alu_result    <= 32'd0;
            mem_zero          <= 1'b0;
            mem_dst           <= 5'd0;
            mem_branch        <= 1'b0;
            mem_wb            <= 1'b0;
        end else begin
            mem_branch_target <= branch_target_s;
            mem_alu_result    <= alu_result_s;
            mem_zero          <= zero_s;
            mem_dst           <= ex_dst;
            mem_branch        <= ex_branch;
            mem_wb            <= ex_wb;
        end
    end

endmodule

// File: tb/tb_decode_execute_core.sv
// Directed bench for decode_execute_core with hand-computed expectations.
module tb_decode_execute_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr_id;
    logic        wb_reg_write;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [31:0] ex_pc, ex_rs_data, ex_rt_data, ex_imm;
    logic        ex_alu_src;
    logic [1:0]  ex_alu_op;
    logic [4:0]  ex_dst;
    logic        ex_branch, ex_wb, fwd_a, fwd_b;
    logic [31:0] mem_branch_target, mem_alu_result;
    logic        mem_zero;
    logic [4:0]  mem_dst;
    logic        mem_branch, mem_wb;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    decode_execute_core dut (
        .clk(clk), .rst(rst), .instr_id(instr_id),
        .wb_reg_write(wb_reg_write), .wb_dst(wb_dst), .wb_data(wb_data),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .ex_pc(ex_pc), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op),
        .ex_dst(ex_dst), .ex_branch(ex_branch), .ex_wb(ex_wb),
        .fwd_a(fwd_a), .fwd_b(fwd_b),
        .mem_branch_target(mem_branch_target), .mem_alu_result(mem_alu_result),
        .mem_zero(mem_zero), .mem_dst(mem_dst),
        .mem_branch(mem_branch), .mem_wb(mem_wb)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_mem(input string tag, input logic [31:0] res, input logic z,
                             input logic [4:0] dst, input logic br, input logic wb,
                             input logic [31:0] tgt);
        check({tag, ".result"}, mem_alu_result, res);
        check({tag, ".zero"},   {31'd0, mem_zero}, {31'd0, z});
        check({tag, ".dst"},    {27'd0, mem_dst}, {27'd0, dst});
        check({tag, ".branch"}, {31'd0, mem_branch}, {31'd0, br});
        check({tag, ".wb"},     {31'd0, mem_wb}, {31'd0, wb});
        check({tag, ".target"}, mem_branch_target, tgt);
    endtask

    initial begin
        rst = 1'b1; instr_id = 32'd0; wb_reg_write = 1'b0; wb_dst = 5'd0; wb_data = 32'd0;
        ex_pc = 32'h0000_0040; ex_rs_data = 32'd3; ex_rt_data = 32'd4; ex_imm = 32'd1;
        ex_alu_src = 1'b0; ex_alu_op = 2'b00; ex_dst = 5'd7;
        ex_branch = 1'b1; ex_wb = 1'b1; fwd_a = 1'b0; fwd_b = 1'b0;

        // Reset clears EX/MEM despite nonzero EX inputs
        step();
        rst = 1'b0;
        check_mem("reset", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);

        // Field extraction and initial register contents
        instr_id = 32'h0022_1820;
        #1;
        check("id_rs", {27'd0, id_rs}, 32'd1);
        check("id_rt", {27'd0, id_rt}, 32'd2);
        check("id_rd", {27'd0, id_rd}, 32'd3);
        check("id_rs_data", id_rs_data, 32'd1);
        check("id_rt_data", id_rt_data, 32'd2);
        check("id_imm_pos", id_imm, 32'h0000_1820);
        instr_id = 32'h03E0_FFFF;
        #1;
        check("id_imm_neg", id_imm, 32'hFFFF_FFFF);
        check("r31_init", id_rs_data, 32'd31);
        check("r0_reads0", id_rt_data, 32'd0);

        // R-type add 5+7
        ex_pc = 32'd0; ex_rs_data = 32'd5; ex_rt_data = 32'd7; ex_alu_op = 2'b10;
        ex_imm = 32'h0000_0020; ex_dst = 5'd3; ex_wb = 1'b1; ex_branch = 1'b0;
        step();
        check_mem("add", 32'd12, 1'b0, 5'd3, 1'b0, 1'b1, 32'h0000_0080);

        // Back-to-back forwarding into A: 12 + 1
        fwd_a = 1'b1; ex_rs_data = 32'd0; ex_rt_data = 32'd1; ex_alu_op = 2'b00; ex_imm = 32'd0;
        step();
        check("fwd_a", mem_alu_result, 32'd13);

        // Forwarding into B: 10 - 13
        fwd_a = 1'b0; fwd_b = 1'b1; ex_rs_data = 32'd10; ex_rt_data = 32'd100; ex_alu_op = 2'b01;
        step();
        check("fwd_b", mem_alu_result, 32'hFFFF_FFFD);
        fwd_b = 1'b0;

        // Branch compare with negative offset
        ex_alu_op = 2'b01; ex_rs_data = 32'd9; ex_rt_data = 32'd9; ex_pc = 32'h0000_0100;
        ex_imm = 32'hFFFF_FFFE; ex_branch = 1'b1; ex_dst = 5'd0; ex_wb = 1'b0;
        step();
        check_mem("beq", 32'd0, 1'b1, 5'd0, 1'b1, 1'b0, 32'h0000_00F8);

        // Funct-decoded operations
        ex_branch = 1'b0; ex_pc = 32'd0; ex_alu_op = 2'b10;
        ex_rs_data = 32'hFFFF_FFFF; ex_rt_data = 32'd1; ex_imm = 32'h0000_002A;
        step();
        check("slt_signed", mem_alu_result, 32'd1);
        ex_rs_data = 32'd5; ex_rt_data = 32'd7; ex_imm = 32'h0000_0022;
        step();
        check("sub_funct", mem_alu_result, 32'hFFFF_FFFE);
        ex_rs_data = 32'h0000_F0F0; ex_rt_data = 32'h0000_0FF0; ex_imm = 32'h0000_0024;
        step();
        check("and_funct", mem_alu_result, 32'h0000_00F0);
        ex_imm = 32'h0000_0025;
        step();
        check("or_funct", mem_alu_result, 32'h0000_FFF0);
        ex_imm = 32'h0000_0021;
        step();
        check("bad_funct", mem_alu_result, 32'd0);
        check("bad_funct_zero", {31'd0, mem_zero}, 32'd1);

        // alu_op 11 is OR
        ex_alu_op = 2'b11; ex_rs_data = 32'd1; ex_rt_data = 32'd2; ex_imm = 32'd0;
        step();
        check("or_op", mem_alu_result, 32'd3);

        // Immediate operand: 4 + (-4)
        ex_alu_src = 1'b1; ex_alu_op = 2'b00; ex_imm = 32'hFFFF_FFFC;
        ex_rs_data = 32'd4; ex_rt_data = 32'd50;
        step();
        check("addi_result", mem_alu_result, 32'd0);
        check("addi_zero", {31'd0, mem_zero}, 32'd1);
        ex_alu_src = 1'b0;

        // Register write with same-cycle bypass
        instr_id = 32'h0080_0000;
        wb_reg_write = 1'b1; wb_dst = 5'd4; wb_data = 32'hDEAD_BEEF;
        #1;
        check("bypass_rs", id_rs_data, 32'hDEAD_BEEF);
        step();
        wb_reg_write = 1'b0;
        #1;
        check("stored_rs", id_rs_data, 32'hDEAD_BEEF);
        instr_id = 32'h0004_0000;
        #1;
        check("stored_rt", id_rt_data, 32'hDEAD_BEEF);

        // Writes to R0 are ignored
        instr_id = 32'h0000_0000;
        wb_reg_write = 1'b1; wb_dst = 5'd0; wb_data = 32'hDEAD_BEEF;
        #1;
        check("r0_bypass", id_rs_data, 32'd0);
        step();
        wb_reg_write = 1'b0;
        #1;
        check("r0_after", id_rs_data, 32'd0);

        // Reset wins over a simultaneous write and reinitialises the file
        ex_rs_data = 32'd1; ex_rt_data = 32'd1; ex_alu_op = 2'b00; ex_wb = 1'b1; ex_dst = 5'd9;
        rst = 1'b1; wb_reg_write = 1'b1; wb_dst = 5'd4; wb_data = 32'h1234_5678;
        step();
        rst = 1'b0; wb_reg_write = 1'b0; instr_id = 32'h0080_0000;
        #1;
        check("rst_prio_r4", id_rs_data, 32'd4);
        check_mem("reset2", 32'd0, 1'b0, 5'd0, 1'b0, 1'b0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
